// File: rtl/uart_rx_cmd_if.sv
// Serial receive bus for uart_rx_cmd: the rx pin in, and the received byte
// with its strobes out toward the VGA display-mode controller.
interface uart_rx_cmd_if;
  logic       rx;
  logic [7:0] data_rx;
  logic       done_rx;
  logic       frame_err;
  logic       parity_err;

  // Receiver side: samples rx and produces the byte and the strobes.
  modport master (
    input  rx,
    output data_rx, done_rx, frame_err, parity_err
  );

  // Line/consumer side: drives rx and observes the byte and the strobes.
  modport slave (
    output rx,
    input  data_rx, done_rx, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: oversampling UART receiver that feeds mode-command bytes to the
// VGA display-mode controller. rx is synchronised into pclk. Start, stop and
// (optionally) parity bits are validated. Each good byte is presented on
// data_rx together with a one-cycle done_rx strobe.
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 11-bit frame with a parity bit. PARITY_ODD selects the sense.
//   undefined -> 8N1 frame. parity_err stays 0.
module uart_rx_cmd #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_ODD = 0
) (
  input logic           pclk,
  input logic           rst_n,
  uart_rx_cmd_if.master bus
);
  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int HALF     = BAUD_CNT / 2;
  localparam int CNT_W    = $clog2(BAUD_CNT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
  logic             par_fault;
  logic             fall, cnt_full, cnt_half;

  // A start edge is a 1->0 transition of the synchronised line. A line that
  // stays low therefore cannot retrigger a frame.
  assign fall     = rx_prev_q & ~rx_s_q;
  assign cnt_full = (cnt_q == CNT_FULL);
  assign cnt_half = (cnt_q == CNT_HALF);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic par_bad_q, par_bad_d;
  assign par_fault = par_bad_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign par_fault = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: the frame advances on half-bit and full-bit counter ticks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (fall) state_d = START;
      START: if (cnt_half) state_d = rx_s_q ? IDLE : DATA;
      DATA: begin
        if (cnt_full && bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_full) state_d = STOP;
`endif
      STOP:  if (cnt_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: counter, shift register, parity flag, and the result
  // strobes at the middle of the stop bit.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: cnt_d = '0;
      START: begin
        if (cnt_half) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      DATA: begin
        if (cnt_full) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_full) begin
          cnt_d     = '0;
          par_bad_d = (rx_s_q != ((^shift_q) ^ PAR_SENSE));
        end
      end
`endif
      STOP: begin
        if (cnt_full) begin
          cnt_d  = '0;
          ferr_d = ~rx_s_q;
          perr_d = par_fault;
          if (rx_s_q && !par_fault) begin
            data_d = shift_q;
            done_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Synchroniser, counters and output registers. The sync flops reset high
  // so that releasing reset does not look like a start edge.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // Shift register holds only datapath bits and needs no reset.
  always_ff @(posedge pclk) begin
    shift_q <= shift_d;
  end

`ifdef UART_RX_PARITY_EN
  // Parity result held from the parity bit until the stop bit is judged.
  always_ff @(posedge pclk) begin
    if (!rst_n) par_bad_q <= 1'b0;
    else        par_bad_q <= par_bad_d;
  end
`endif

  assign bus.data_rx    = data_q;
  assign bus.done_rx    = done_q;
  assign bus.frame_err  = ferr_q;
  assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Bench for uart_rx_cmd. Each frame sent pushes its expected outcome (good
// byte, frame error and/or parity error) onto a queue. A negedge monitor pops
// one entry per observed strobe and checks the strobe kind. It also tracks the
// last good byte that data_rx must hold. Directed tests add literal checks.
`timescale 1ns/1ps
module tb_uart_rx_cmd;
  localparam int BIT   = 217;
  localparam bit P_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_NOM = 2064 + BIT;
`else
  localparam int LAT_NOM = 2064;
`endif

  typedef struct {
    logic [7:0] b;
    bit         fe;
    bit         pe;
  } ev_t;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  logic in_rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  int   done_cyc = 0, start_cyc = 0;
  logic [7:0] exp_data = 8'h00;
  logic [2:0] prev_str = 3'b000;
  ev_t  exp_q[$];

  uart_rx_cmd_if bus();

  uart_rx_cmd #(.CLK_FREQ(25_000_000), .BAUD(115200), .PARITY_ODD(0)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 pclk = ~pclk;

  always @(posedge pclk) begin
    cyc    <= cyc + 1;
    in_rst <= !rst_n;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the next expected frame outcome, and
  // data_rx must always equal the last good byte.
  always @(negedge pclk) begin
    logic [2:0] cur;
    ev_t ev;
    cur = {bus.done_rx, bus.frame_err, bus.parity_err};
    if (in_rst) begin
      chk("reset_outputs", {bus.data_rx, cur}, 32'd0);
      exp_q.delete();
      exp_data = 8'h00;
      prev_str = 3'b000;
    end else begin
      if (cur != 3'b000) begin
        if (bus.done_rx)    begin done_cnt++; done_cyc = cyc; end
        if (bus.frame_err)  fe_cnt++;
        if (bus.parity_err) pe_cnt++;
        chk("strobe_back_to_back", prev_str & cur, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", cur, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_kind", cur, {(!ev.fe && !ev.pe), ev.fe, ev.pe});
          if (!ev.fe && !ev.pe) exp_data = ev.b;
        end
      end
      chk("data_rx_hold", bus.data_rx, exp_data);
      prev_str = cur;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Sends one frame LSB first and records what the receiver must report.
  task automatic send(input logic [7:0] b, input bit stop_v, input bit par_flip);
    logic [10:0] bits;
    int nb;
    ev_t ev;
    ev.b  = b;
    ev.fe = !stop_v;
`ifdef UART_RX_PARITY_EN
    ev.pe = par_flip;
    bits  = {stop_v, (^b) ^ P_ODD ^ par_flip, b, 1'b0};
    nb    = 11;
`else
    ev.pe = 1'b0;
    if (par_flip) $display("note: parity flip has no effect in the 8N1 build");
    bits  = {1'b1, stop_v, b, 1'b0};
    nb    = 10;
`endif
    exp_q.push_back(ev);
    start_cyc = cyc;
    for (int i = 0; i < nb; i++) begin
      bus.rx = bits[i];
      idle(BIT);
    end
    bus.rx = 1'b1;
  endtask

  initial begin
    int d0, f0, p0;
    logic [7:0] rb;
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    idle(5);
    chk("reset_state", {bus.data_rx, bus.done_rx, bus.frame_err, bus.parity_err}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    // 1: single byte, latency to done_rx.
    d0 = done_cnt;
    send(8'h02, 1'b1, 1'b0);
    idle(BIT);
    chk("t1_queue_empty", exp_q.size(), 32'd0);
    chk("t1_done_count", done_cnt - d0, 32'd1);
    chk("t1_data", bus.data_rx, 8'h02);
    chk("t1_latency_window",
        ((done_cyc - start_cyc) >= LAT_NOM - 4) && ((done_cyc - start_cyc) <= LAT_NOM + 4), 32'd1);

    // 2: two frames with no idle gap.
    d0 = done_cnt; f0 = fe_cnt;
    send(8'h01, 1'b1, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    idle(BIT);
    chk("t2_queue_empty", exp_q.size(), 32'd0);
    chk("t2_done_count", done_cnt - d0, 32'd2);
    chk("t2_no_frame_err", fe_cnt - f0, 32'd0);
    chk("t2_data", bus.data_rx, 8'h03);

    // 3: 50-cycle glitch is rejected, then a real byte.
    d0 = done_cnt; f0 = fe_cnt; p0 = pe_cnt;
    bus.rx = 1'b0;
    idle(50);
    bus.rx = 1'b1;
    idle(3 * BIT);
    chk("t3_glitch_silent", (done_cnt - d0) + (fe_cnt - f0) + (pe_cnt - p0), 32'd0);
    send(8'hA5, 1'b1, 1'b0);
    idle(BIT);
    chk("t3_queue_empty", exp_q.size(), 32'd0);
    chk("t3_data", bus.data_rx, 8'hA5);

    // 4: stop bit low gives frame_err and keeps the old byte.
    send(8'h01, 1'b1, 1'b0);
    idle(BIT);
    d0 = done_cnt; f0 = fe_cnt;
    send(8'h55, 1'b0, 1'b0);
    idle(2 * BIT);
    chk("t4_frame_err_count", fe_cnt - f0, 32'd1);
    chk("t4_no_done", done_cnt - d0, 32'd0);
    chk("t4_data_kept", bus.data_rx, 8'h01);
    send(8'h03, 1'b1, 1'b0);
    idle(BIT);
    chk("t4_queue_empty", exp_q.size(), 32'd0);
    chk("t4_recover_data", bus.data_rx, 8'h03);

    // 5: reset during data bit 4 aborts the frame.
    rb = 8'h03;
    d0 = done_cnt; f0 = fe_cnt; p0 = pe_cnt;
    bus.rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      bus.rx = rb[i];
      idle(BIT);
    end
    bus.rx = rb[4];
    idle(100);
    rst_n = 1'b0;
    idle(5);
    chk("t5_outputs_in_reset", {bus.data_rx, bus.done_rx, bus.frame_err, bus.parity_err}, 32'd0);
    bus.rx = 1'b1;
    rst_n  = 1'b1;
    idle(3 * BIT);
    chk("t5_no_strobe", (done_cnt - d0) + (fe_cnt - f0) + (pe_cnt - p0), 32'd0);
    chk("t5_data_cleared", bus.data_rx, 8'h00);
    send(8'h02, 1'b1, 1'b0);
    idle(BIT);
    chk("t5_queue_empty", exp_q.size(), 32'd0);
    chk("t5_data", bus.data_rx, 8'h02);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, good then corrupted parity bit.
    d0 = done_cnt; p0 = pe_cnt;
    send(8'h03, 1'b1, 1'b0);
    idle(BIT);
    chk("t6_good_done", done_cnt - d0, 32'd1);
    chk("t6_good_data", bus.data_rx, 8'h03);
    send(8'h05, 1'b1, 1'b0);
    idle(BIT);
    d0 = done_cnt;
    send(8'h03, 1'b1, 1'b1);
    idle(2 * BIT);
    chk("t6_parity_err_count", pe_cnt - p0, 32'd1);
    chk("t6_bad_no_done", done_cnt - d0, 32'd0);
    chk("t6_data_kept", bus.data_rx, 8'h05);
    chk("t6_queue_empty", exp_q.size(), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
